rmii_tx_reader: RTL and testbench

RMII_TX_READER -- requirements
Module: rmii_tx_reader

---
 rtl/rmii_tx_reader_if.sv | 25 ++
 rtl/rmii_tx_reader.sv | 117 +++++++++++
 tb/tb_rmii_tx_reader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rmii_tx_reader_if.sv
// Buffer-read and RMII transmit signals between a frame source (master) and rmii_tx_reader (slave).
// The bench drives i_data_in combinationally from o_addr_read to model the buffer.
interface rmii_tx_reader_if #(
    parameter int unsigned AW = 9
) ();
    logic          i_start;
    logic [AW-1:0] i_length;
    logic [AW-1:0] o_addr_read;
    logic [1:0]    i_data_in;
    logic [1:0]    o_txd;
    logic          o_tx_en;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    modport master (
        output i_start, i_length, i_data_in,
        input  o_addr_read, o_txd, o_tx_en, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_length, i_data_in,
        output o_addr_read, o_txd, o_tx_en, o_busy, o_done, o_err
    );
endinterface

// File: rtl/rmii_tx_reader.sv
// Streams a buffered frame onto RMII TXD/TX_EN: 32-dibit preamble+SFD, L data dibits, then IPG.
// The buffer is read one dibit ahead so every output stays registered.
module rmii_tx_reader #(
    parameter int unsigned DEPTH      = 288,
    parameter int unsigned AW         = 9,
    parameter int unsigned IPG_DIBITS = 48
) (
    input logic              i_clock,
    input logic              i_reset_n,
    rmii_tx_reader_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StPreamble, StData, StIpg} state_e;

    localparam logic [AW:0]   DepthW  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PreSfd  = AW'(30);
    localparam logic [AW-1:0] PreLast = AW'(31);
    localparam logic [AW-1:0] IpgLast = AW'(IPG_DIBITS - 1);

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] addr_q;
    logic [1:0]    txd_q;
    logic          tx_en_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic          len_ok;
    logic          last_data;
    logic [AW:0]   cnt_plus2;

    assign len_ok    = (bus.i_length != '0) && ({1'b0, bus.i_length} <= DepthW);
    assign last_data = (cnt_q == len_q - AW'(1));
    assign cnt_plus2 = {1'b0, cnt_q} + (AW+1)'(2);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            txd_q   <= 2'b00;
            tx_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        if (len_ok) begin
                            state_q <= StPreamble;
                            len_q   <= bus.i_length;
                            cnt_q   <= '0;
                            addr_q  <= '0;
                            txd_q   <= 2'b01;
                            tx_en_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StPreamble: begin
                    if (cnt_q == PreLast) begin
                        // buffer[0] is on i_data_in because addr_q has been 0 all preamble
                        state_q <= StData;
                        cnt_q   <= '0;
                        txd_q   <= bus.i_data_in;
                        addr_q  <= (len_q > AW'(1)) ? AW'(1) : '0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                        if (cnt_q == PreSfd) begin
                            txd_q <= 2'b11;
                        end
                    end
                end
                StData: begin
                    if (last_data) begin
                        state_q <= StIpg;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                        txd_q   <= 2'b00;
                        tx_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + AW'(1);
                        txd_q  <= bus.i_data_in;
                        // Fetch one ahead, but park on the last dibit instead of running past it
                        addr_q <= (cnt_plus2 < {1'b0, len_q}) ? cnt_plus2[AW-1:0]
                                                                : len_q - AW'(1);
                    end
                end
                StIpg: begin
                    if (cnt_q == IpgLast) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_addr_read = addr_q;
    assign bus.o_txd       = txd_q;
    assign bus.o_tx_en     = tx_en_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;
endmodule

// File: tb/tb_rmii_tx_reader.sv
// Bench for rmii_tx_reader: start-decision table, directed frames, mid-frame reset and
// random frames checked cycle by cycle against a per-cycle frame-timeline model.
module tb_rmii_tx_reader;
    localparam int DEPTH = 288;
    localparam int AW    = 9;
    localparam int IPG   = 48;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    rmii_tx_reader_if #(.AW(AW)) bus ();
    logic [1:0] mem [512];
    assign bus.i_data_in = mem[bus.o_addr_read];

    rmii_tx_reader #(.DEPTH(DEPTH), .AW(AW), .IPG_DIBITS(IPG)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] obs;
    assign obs = {bus.o_tx_en, bus.o_txd, bus.o_busy, bus.o_done, bus.o_err};

    typedef struct {
        int len;
        bit acc;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {tx_en, txd, busy, done, err} for cycle n after the start was sampled (n = 1 is first TX)
    function automatic logic [6:0] exp_out(input int n, input int len);
        if (n <= 31)             return {1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
        if (n == 32)             return {1'b1, 2'b11, 1'b1, 1'b0, 1'b0};
        if (n <= 32 + len)       return {1'b1, mem[n - 33], 1'b1, 1'b0, 1'b0};
        if (n <= 32 + len + IPG) return {1'b0, 2'b00, 1'b1, n == 33 + len, 1'b0};
        return 7'b0;
    endfunction

    function automatic int exp_addr(input int n, input int len);
        int k;
        if (n == 32) return 0;
        k = n - 33;
        return (k + 1 < len) ? k + 1 : len - 1;
    endfunction

    // Called at a negedge in IDLE; issues the start and follows the frame into the first IDLE cycle.
    task automatic run_frame(input int len, input bit noise);
        bus.i_start  = 1'b1;
        bus.i_length = AW'(len);
        for (int n = 1; n <= len + 33 + IPG; n++) begin
            @(negedge clk);
            bus.i_start  = noise && (n <= len + 32 + IPG) && ($urandom_range(0, 3) == 0);
            bus.i_length = AW'($urandom);
            check("frame_out", 32'(obs), 32'(exp_out(n, len)));
            if (n >= 32 && n <= len + 32) begin
                check("addr", 32'(bus.o_addr_read), 32'(exp_addr(n, len)));
            end
            check("addr_range", 32'(int'(bus.o_addr_read) < DEPTH), 32'(1));
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom);
    endtask

    initial begin
        bus.i_start  = 1'b0;
        bus.i_length = '0;
        for (int i = 0; i < 512; i++) mem[i] = 2'b00;

        repeat (2) @(negedge clk);
        check("reset_out", 32'(obs), 32'(0));
        check("reset_addr", 32'(bus.o_addr_read), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Start decisions: rejected lengths pulse err only, accepted ones raise busy and TX_EN
        vecs[0] = '{len: 0,   acc: 1'b0};
        vecs[1] = '{len: 289, acc: 1'b0};
        vecs[2] = '{len: 511, acc: 1'b0};
        vecs[3] = '{len: 300, acc: 1'b0};
        vecs[4] = '{len: 1,   acc: 1'b1};
        vecs[5] = '{len: 288, acc: 1'b1};
        vecs[6] = '{len: 2,   acc: 1'b1};
        vecs[7] = '{len: 37,  acc: 1'b1};
        for (int v = 0; v < 8; v++) begin
            bit timed_out;
            bus.i_start  = 1'b1;
            bus.i_length = AW'(vecs[v].len);
            @(negedge clk);
            bus.i_start = 1'b0;
            check("start_decision", 32'({bus.o_tx_en, bus.o_busy, bus.o_err}),
                  32'(vecs[v].acc ? 3'b110 : 3'b001));
            @(negedge clk);
            check("err_one_cycle", 32'({bus.o_err, bus.o_busy}), 32'({1'b0, vecs[v].acc}));
            timed_out = 1'b1;
            for (int c = 0; c < 600; c++) begin
                if (!bus.o_busy) begin
                    timed_out = 1'b0;
                    break;
                end
                @(negedge clk);
            end
            check("busy_release", 32'(timed_out), 32'(0));
            @(negedge clk);
        end

        // Directed L=4 frame, then back-to-back with stray starts inside each frame
        mem[0] = 2'b10; mem[1] = 2'b01; mem[2] = 2'b11; mem[3] = 2'b00;
        run_frame(4, 1'b0);
        run_frame(4, 1'b1);
        run_frame(4, 1'b1);

        // Full-depth frame sweeps every address with no wrap
        for (int i = 0; i < DEPTH; i++) mem[i] = 2'(i);
        run_frame(DEPTH, 1'b0);

        // Reset at data cycle 10 of a 60-dibit frame
        fill_random();
        bus.i_start  = 1'b1;
        bus.i_length = AW'(60);
        for (int n = 1; n <= 43; n++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            check("pre_reset_out", 32'(obs), 32'(exp_out(n, 60)));
        end
        #2 rst_n = 1'b0;
        #1;
        check("reset_truncate", 32'(obs), 32'(0));
        check("reset_truncate_addr", 32'(bus.o_addr_read), 32'(0));
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", 32'(obs), 32'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(60, 1'b0);

        // Random frames, random buffer contents, random stray starts and length noise
        for (int f = 0; f < 10; f++) begin
            int len;
            fill_random();
            len = (f < 3) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, DEPTH));
            run_frame(len, f[0]);
        end

        @(negedge clk);
        check("final_idle", 32'(obs), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
